// File: rtl/gat_pkg.sv
// Shared types and constants for the GAT input loader: FSM states, region indices,
// BRAM data widths and per-region default depths / address widths.
package gat_pkg;

   localparam int unsigned H_DATA_WIDTH    = 16;
   localparam int unsigned NODE_INFO_WIDTH = 8;
   localparam int unsigned DATA_WIDTH      = 16;

   localparam int unsigned H_DEPTH_DEF    = 16;
   localparam int unsigned NODE_DEPTH_DEF = 8;
   localparam int unsigned WGT_DEPTH_DEF  = 16;
   localparam int unsigned A_DEPTH_DEF    = 8;

   // Address widths are sized for the default depths; smaller depths reuse them.
   localparam int unsigned H_DATA_ADDR_W    = $clog2(H_DEPTH_DEF);
   localparam int unsigned NODE_INFO_ADDR_W = $clog2(NODE_DEPTH_DEF);
   localparam int unsigned WEIGHT_ADDR_W    = $clog2(WGT_DEPTH_DEF);
   localparam int unsigned A_ADDR_W         = $clog2(A_DEPTH_DEF);

   typedef enum logic [2:0] {
      StIdle,
      StLdH,
      StLdNode,
      StLdWgt,
      StLdA,
      StDone
   } ld_state_e;

   typedef enum logic [1:0] {
      RgnH,
      RgnNode,
      RgnWgt,
      RgnA
   } ld_region_e;

   // Region that the next accepted word belongs to; IDLE feeds H word 0.
   function automatic ld_region_e region_of(ld_state_e s);
      unique case (s)
         StIdle, StLdH: return RgnH;
         StLdNode:      return RgnNode;
         StLdWgt:       return RgnWgt;
         default:       return RgnA;
      endcase
   endfunction

   function automatic ld_state_e state_after(ld_region_e r);
      unique case (r)
         RgnH:    return StLdNode;
         RgnNode: return StLdWgt;
         RgnWgt:  return StLdA;
         default: return StDone;
      endcase
   endfunction

endpackage

// File: rtl/loader_region_ctr.sv
// Per-region word counter with terminal-count flag; LOADER_CHKSUM_EN adds a trailer
// phase that checks a running sum of the region's data words.
module loader_region_ctr #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              inc_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [ADDR_W-1:0] cnt_o,
   output logic              wr_o,
   output logic              tc_o,
   output logic              err_o
);

   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              last;

   assign last  = (cnt_q == ADDR_W'(DEPTH - 1));
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (wr_o) begin
         cnt_d = last ? '0 : cnt_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

`ifdef LOADER_CHKSUM_EN
   logic              trl_q, trl_d;
   logic [DATA_W-1:0] sum_q, sum_d;

   assign wr_o  = inc_i & ~trl_q;
   assign tc_o  = inc_i & trl_q;
   assign err_o = inc_i & trl_q & (data_i != sum_q);

   always_comb begin
      trl_d = trl_q;
      sum_d = sum_q;
      if (clear_i) begin
         trl_d = 1'b0;
         sum_d = '0;
      end else if (wr_o) begin
         sum_d = sum_q + data_i;
         if (last) trl_d = 1'b1;
      end else if (tc_o) begin
         trl_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trl_q <= 1'b0;
         sum_q <= '0;
      end else begin
         trl_q <= trl_d;
         sum_q <= sum_d;
      end
   end
`else
   logic unused_data;

   assign unused_data = ^data_i;
   assign wr_o        = inc_i;
   assign tc_o        = inc_i & last;
   assign err_o       = 1'b0;
`endif

endmodule

// File: rtl/gat_input_loader.sv
// Streams H data, node info, weights and `a` into gat_top's input BRAM A ports in a fixed
// region order. Optional trailer checksum per region via LOADER_CHKSUM_EN.
module gat_input_loader
   import gat_pkg::*;
#(
   parameter int unsigned LD_DATA_W  = 32,
   parameter int unsigned H_DEPTH    = H_DEPTH_DEF,
   parameter int unsigned NODE_DEPTH = NODE_DEPTH_DEF,
   parameter int unsigned WGT_DEPTH  = WGT_DEPTH_DEF,
   parameter int unsigned A_DEPTH    = A_DEPTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear_i,
   input  logic                        ld_vld_i,
   output logic                        ld_rdy_o,
   input  logic [LD_DATA_W-1:0]        ld_data_i,
   output logic [H_DATA_WIDTH-1:0]     h_data_bram_din,
   output logic                        h_data_bram_ena,
   output logic [H_DATA_ADDR_W-1:0]    h_data_bram_addra,
   output logic [NODE_INFO_WIDTH-1:0]  h_node_info_bram_din,
   output logic                        h_node_info_bram_ena,
   output logic [NODE_INFO_ADDR_W-1:0] h_node_info_bram_addra,
   output logic [DATA_WIDTH-1:0]       wgt_bram_din,
   output logic                        wgt_bram_ena,
   output logic [WEIGHT_ADDR_W-1:0]    wgt_bram_addra,
   output logic [DATA_WIDTH-1:0]       a_bram_din,
   output logic                        a_bram_ena,
   output logic [A_ADDR_W-1:0]         a_bram_addra,
   output logic                        h_data_bram_load_done,
   output logic                        h_node_info_bram_load_done,
   output logic                        wgt_bram_load_done,
   output logic                        a_bram_load_done,
   output logic                        chk_err_o,
   output logic                        all_done_o
);

   ld_state_e  state_q, state_d;
   ld_region_e cur_rgn;
   logic       acc;
   logic [3:0] inc, wr, tc, err;
   logic [3:0] done_q, done_set;

   logic [H_DATA_ADDR_W-1:0]    cnt_h;
   logic [NODE_INFO_ADDR_W-1:0] cnt_node;
   logic [WEIGHT_ADDR_W-1:0]    cnt_wgt;
   logic [A_ADDR_W-1:0]         cnt_a;

   assign ld_rdy_o = ~clear_i & (state_q != StDone);
   assign acc      = ld_vld_i & ld_rdy_o;
   assign cur_rgn  = region_of(state_q);
   assign inc      = acc ? (4'b0001 << cur_rgn) : 4'b0000;

   loader_region_ctr #(.DEPTH(H_DEPTH), .ADDR_W(H_DATA_ADDR_W), .DATA_W(LD_DATA_W)) u_ctr_h (
      .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .inc_i(inc[RgnH]), .data_i(ld_data_i),
      .cnt_o(cnt_h), .wr_o(wr[RgnH]), .tc_o(tc[RgnH]), .err_o(err[RgnH])
   );

   loader_region_ctr #(.DEPTH(NODE_DEPTH), .ADDR_W(NODE_INFO_ADDR_W), .DATA_W(LD_DATA_W)) u_ctr_node (
      .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .inc_i(inc[RgnNode]), .data_i(ld_data_i),
      .cnt_o(cnt_node), .wr_o(wr[RgnNode]), .tc_o(tc[RgnNode]), .err_o(err[RgnNode])
   );

   loader_region_ctr #(.DEPTH(WGT_DEPTH), .ADDR_W(WEIGHT_ADDR_W), .DATA_W(LD_DATA_W)) u_ctr_wgt (
      .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .inc_i(inc[RgnWgt]), .data_i(ld_data_i),
      .cnt_o(cnt_wgt), .wr_o(wr[RgnWgt]), .tc_o(tc[RgnWgt]), .err_o(err[RgnWgt])
   );

   loader_region_ctr #(.DEPTH(A_DEPTH), .ADDR_W(A_ADDR_W), .DATA_W(LD_DATA_W)) u_ctr_a (
      .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .inc_i(inc[RgnA]), .data_i(ld_data_i),
      .cnt_o(cnt_a), .wr_o(wr[RgnA]), .tc_o(tc[RgnA]), .err_o(err[RgnA])
   );

   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = StIdle;
      end else if (acc) begin
         if (tc[cur_rgn])            state_d = state_after(cur_rgn);
         else if (state_q == StIdle) state_d = StLdH;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q                <= StIdle;
         h_data_bram_ena        <= 1'b0;
         h_data_bram_addra      <= '0;
         h_data_bram_din        <= '0;
         h_node_info_bram_ena   <= 1'b0;
         h_node_info_bram_addra <= '0;
         h_node_info_bram_din   <= '0;
         wgt_bram_ena           <= 1'b0;
         wgt_bram_addra         <= '0;
         wgt_bram_din           <= '0;
         a_bram_ena             <= 1'b0;
         a_bram_addra           <= '0;
         a_bram_din             <= '0;
         done_q                 <= '0;
      end else begin
         state_q              <= state_d;
         h_data_bram_ena      <= wr[RgnH];
         h_node_info_bram_ena <= wr[RgnNode];
         wgt_bram_ena         <= wr[RgnWgt];
         a_bram_ena           <= wr[RgnA];
         if (wr[RgnH]) begin
            h_data_bram_addra <= cnt_h;
            h_data_bram_din   <= ld_data_i[H_DATA_WIDTH-1:0];
         end
         if (wr[RgnNode]) begin
            h_node_info_bram_addra <= cnt_node;
            h_node_info_bram_din   <= ld_data_i[NODE_INFO_WIDTH-1:0];
         end
         if (wr[RgnWgt]) begin
            wgt_bram_addra <= cnt_wgt;
            wgt_bram_din   <= ld_data_i[DATA_WIDTH-1:0];
         end
         if (wr[RgnA]) begin
            a_bram_addra <= cnt_a;
            a_bram_din   <= ld_data_i[DATA_WIDTH-1:0];
         end
         done_q <= clear_i ? 4'b0000 : (done_q | done_set);
      end
   end

`ifdef LOADER_CHKSUM_EN
   logic chk_err_q;

   // Trailer acceptance completes the region, so done and error both land at N+1.
   assign done_set  = tc;
   assign chk_err_o = chk_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chk_err_q <= 1'b0;
      else        chk_err_q <= clear_i ? 1'b0 : (chk_err_q | (|err));
   end
`else
   logic [3:0] fin_q;
   logic       unused_err;

   // fin_q aligns with the last write strobe so done follows it by one cycle.
   assign done_set   = fin_q;
   assign chk_err_o  = 1'b0;
   assign unused_err = ^err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fin_q <= '0;
      else        fin_q <= clear_i ? 4'b0000 : tc;
   end
`endif

   assign h_data_bram_load_done      = done_q[RgnH];
   assign h_node_info_bram_load_done = done_q[RgnNode];
   assign wgt_bram_load_done         = done_q[RgnWgt];
   assign a_bram_load_done           = done_q[RgnA];
   assign all_done_o                 = &done_q;

endmodule

// File: tb/tb_gat_input_loader.sv
// Scoreboard bench for gat_input_loader with depths 4/2/3/2; checksum scenario runs
// only when LOADER_CHKSUM_EN is defined.
module tb_gat_input_loader;
   import gat_pkg::*;

   localparam int TOTAL = 11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear_i = 1'b0;
   logic ld_vld_i = 1'b0;
   logic [31:0] ld_data_i = '0;
   logic ld_rdy_o;
   logic [H_DATA_WIDTH-1:0] h_din;
   logic h_ena;
   logic [H_DATA_ADDR_W-1:0] h_addr;
   logic [NODE_INFO_WIDTH-1:0] n_din;
   logic n_ena;
   logic [NODE_INFO_ADDR_W-1:0] n_addr;
   logic [DATA_WIDTH-1:0] w_din;
   logic w_ena;
   logic [WEIGHT_ADDR_W-1:0] w_addr;
   logic [DATA_WIDTH-1:0] a_din;
   logic a_ena;
   logic [A_ADDR_W-1:0] a_addr;
   logic h_done, n_done, w_done, a_done, chk_err, all_done;

   gat_input_loader #(
      .LD_DATA_W(32), .H_DEPTH(4), .NODE_DEPTH(2), .WGT_DEPTH(3), .A_DEPTH(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .ld_vld_i(ld_vld_i), .ld_rdy_o(ld_rdy_o),
      .ld_data_i(ld_data_i),
      .h_data_bram_din(h_din), .h_data_bram_ena(h_ena), .h_data_bram_addra(h_addr),
      .h_node_info_bram_din(n_din), .h_node_info_bram_ena(n_ena),
      .h_node_info_bram_addra(n_addr),
      .wgt_bram_din(w_din), .wgt_bram_ena(w_ena), .wgt_bram_addra(w_addr),
      .a_bram_din(a_din), .a_bram_ena(a_ena), .a_bram_addra(a_addr),
      .h_data_bram_load_done(h_done), .h_node_info_bram_load_done(n_done),
      .wgt_bram_load_done(w_done), .a_bram_load_done(a_done),
      .chk_err_o(chk_err), .all_done_o(all_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          rgn;
      int          addr;
      logic [15:0] din;
      bit          last;
   } wr_t;

   wr_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int word_cnt = 0;
   logic [3:0] exp_done = '0;
   logic [3:0] pend = '0;
   bit chk_mode = 1'b0;

   function automatic wr_t expect_of(int k, logic [31:0] d);
      wr_t e;
      if (k < 4) begin
         e.rgn = 0; e.addr = k; e.din = d[15:0]; e.last = (k == 3);
      end else if (k < 6) begin
         e.rgn = 1; e.addr = k - 4; e.din = {8'h00, d[7:0]}; e.last = (k == 5);
      end else if (k < 9) begin
         e.rgn = 2; e.addr = k - 6; e.din = d[15:0]; e.last = (k == 8);
      end else begin
         e.rgn = 3; e.addr = k - 9; e.din = d[15:0]; e.last = (k == 10);
      end
      return e;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      exp_done = '0;
      pend = '0;
      word_cnt = 0;
   endtask

   // Write monitor: pops the scoreboard on each strobe and tracks expected done flags.
   always @(negedge clk) begin
      int n, rgn, addr;
      logic [15:0] din;
      wr_t e;
      if (rst_n) begin
         exp_done = exp_done | pend;
         pend = '0;
         if (!chk_mode) begin
            checks++;
            if ({a_done, w_done, n_done, h_done} !== exp_done) begin
               errors++;
               $display("FAIL done_flags: got %b want %b", {a_done, w_done, n_done, h_done},
                        exp_done);
            end
            checks++;
            if (all_done !== (&exp_done)) begin
               errors++;
               $display("FAIL all_done: got %b want %b", all_done, &exp_done);
            end
         end
         n = int'(h_ena) + int'(n_ena) + int'(w_ena) + int'(a_ena);
         if (n != 0) begin
            checks++;
            if (n != 1) begin
               errors++;
               $display("FAIL ena_onehot: got %0d strobes want 1", n);
            end
            if (h_ena) begin rgn = 0; addr = int'(h_addr); din = h_din; end
            else if (n_ena) begin rgn = 1; addr = int'(n_addr); din = {8'h00, n_din}; end
            else if (w_ena) begin rgn = 2; addr = int'(w_addr); din = w_din; end
            else begin rgn = 3; addr = int'(a_addr); din = a_din; end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got rgn %0d addr %0d din %h want none",
                        rgn, addr, din);
            end else begin
               e = exp_q.pop_front();
               if (rgn != e.rgn || addr != e.addr || din !== e.din) begin
                  errors++;
                  $display("FAIL bram_write: got rgn %0d addr %0d din %h want rgn %0d addr %0d din %h",
                           rgn, addr, din, e.rgn, e.addr, e.din);
               end
               if (e.last) pend[e.rgn] = 1'b1;
            end
         end
      end
   end

   task automatic send_word(input logic [31:0] d);
      bit r;
      @(negedge clk);
      ld_vld_i = 1'b1;
      ld_data_i = d;
      #1;
      r = (word_cnt < TOTAL);
      checks++;
      if (ld_rdy_o !== r) begin
         errors++;
         $display("FAIL ld_rdy: got %b want %b (word %0d)", ld_rdy_o, r, word_cnt);
      end
      if (r) begin
         exp_q.push_back(expect_of(word_cnt, d));
         word_cnt++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         ld_vld_i = 1'b0;
      end
   endtask

   task automatic do_clear(input bit offer);
      @(negedge clk);
      clear_i = 1'b1;
      ld_vld_i = offer;
      ld_data_i = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (ld_rdy_o !== 1'b0) begin
         errors++;
         $display("FAIL clear_rdy: got %b want 0", ld_rdy_o);
      end
      @(posedge clk);
      #1;
      model_reset();
      checks++;
      if ({a_done, w_done, n_done, h_done, chk_err} !== 5'b0) begin
         errors++;
         $display("FAIL clear_flags: got %b want 00000", {a_done, w_done, n_done, h_done, chk_err});
      end
      @(negedge clk);
      clear_i = 1'b0;
      ld_vld_i = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if ({h_ena, n_ena, w_ena, a_ena, h_addr, n_addr, w_addr, a_addr} !== '0 ||
          {h_din, n_din, w_din, a_din} !== '0) begin
         errors++;
         $display("FAIL %s_bram: got ena %b addr %h/%h/%h/%h din %h/%h/%h/%h want all 0", tag,
                  {h_ena, n_ena, w_ena, a_ena}, h_addr, n_addr, w_addr, a_addr,
                  h_din, n_din, w_din, a_din);
      end
      checks++;
      if ({a_done, w_done, n_done, h_done, chk_err, all_done, ld_rdy_o} !== 7'b0000001) begin
         errors++;
         $display("FAIL %s_flags: got %b want 0000001", tag,
                  {a_done, w_done, n_done, h_done, chk_err, all_done, ld_rdy_o});
      end
   endtask

   task automatic check_all_done(input string tag);
      checks++;
      if (all_done !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: got all_done %b pending %0d want 1 pending 0", tag, all_done,
                  exp_q.size());
      end
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic test_continuous();
      for (int k = 1; k <= TOTAL; k++) send_word(k);
      idle(3);
      check_all_done("continuous_done");
   endtask

   task automatic test_done_blocks();
      for (int i = 0; i < 3; i++) send_word($urandom);
      idle(2);
   endtask

   task automatic test_clear_and_gaps();
      do_clear(1'b0);
      for (int i = 0; i < 6; i++) send_word($urandom);
      do_clear(1'b1);
      send_word(32'h55);
      for (int i = 1; i < TOTAL; i++) begin
         if ($urandom_range(1) == 1) idle(1);
         send_word($urandom);
      end
      idle(3);
      check_all_done("gaps_done");
   endtask

   task automatic test_rst_mid();
      do_clear(1'b0);
      for (int i = 0; i < 7; i++) send_word(100 + i);
      idle(1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      @(negedge clk);
      #2 rst_n = 1'b1;
      for (int k = 0; k < TOTAL; k++) send_word(32'h200 + k);
      idle(3);
      check_all_done("reload_done");
   endtask

   task automatic send_raw(input logic [31:0] d);
      @(negedge clk);
      ld_vld_i = 1'b1;
      ld_data_i = d;
      #1;
      checks++;
      if (ld_rdy_o !== 1'b1) begin
         errors++;
         $display("FAIL trailer_rdy: got %b want 1", ld_rdy_o);
      end
   endtask

   task automatic test_chksum();
      logic [31:0] trl [2];
      trl[0] = 32'd10;
      trl[1] = 32'd11;
      chk_mode = 1'b1;
      for (int p = 0; p < 2; p++) begin
         if (p == 1) do_clear(1'b0);
         for (int k = 1; k <= 4; k++) send_word(k);
         send_raw(trl[p]);
         idle(3);
         checks++;
         if (chk_err !== (p == 1) || h_done !== 1'b1) begin
            errors++;
            $display("FAIL chksum_%0d: got err %b h_done %b want err %b h_done 1", p, chk_err,
                     h_done, (p == 1));
         end
      end
   endtask

   initial begin
      test_reset();
`ifdef LOADER_CHKSUM_EN
      test_chksum();
`else
      test_continuous();
      test_done_blocks();
      test_clear_and_gaps();
      test_rst_mid();
`endif
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
